// File: rtl/ringosc_meas_seq.sv
// -----------------------------------------------------------------------------
// ringosc_meas_seq
//
// Measurement sequencer for the ring-oscillator ripple-counter macro. For
// each measurement it clears the counter, ungates the oscillator for a
// programmed number of clk cycles, re-gates it, waits for the ripple chain
// to settle, then walks the counter's byte-shift select through
// 0, 8, ..., 56 to assemble the 64-bit count. The finished count is handed
// to the host over a valid/ready result port.
//
// Optional feature (compile-time macro RINGOSC_SEQ_CONT_EN):
//   defined   - a result handshake with cont=1 immediately starts another
//               measurement using the current win_cycles.
//   undefined - cont is ignored; every measurement needs start.
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   start       in   request one measurement (level-sampled)
//   cont        in   continuous-mode request (macro-dependent)
//   win_cycles  in   oscillator-enabled window in clk cycles (0 acts as 1)
//   busy        out  high from start acceptance until res_valid rises
//   osc_stop    out  counter macro stop pin, 1 = oscillator halted
//   osc_clear   out  counter macro reset pin, 1 = counter cleared
//   osc_shift   out  counter macro shift select (0, 8, ..., 56)
//   osc_byte    in   counter macro output byte, (count >> osc_shift)[7:0]
//   res_valid   out  result available
//   res_ready   in   host accepts result
//   res_count   out  captured 64-bit count
// -----------------------------------------------------------------------------
module ringosc_meas_seq #(
  parameter int WIN_W         = 16,
  parameter int CLR_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int READ_WAIT     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic [WIN_W-1:0] win_cycles,
  output logic             busy,
  output logic             osc_stop,
  output logic             osc_clear,
  output logic [5:0]       osc_shift,
  input  logic [7:0]       osc_byte,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [63:0]      res_count
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One phase counter serves CLEAR, SETTLE and READ; it is loaded with
  // (duration - 1) on entry and the state is left when it reaches zero.
  localparam int PH_MAX = max_of(CLR_CYCLES, max_of(SETTLE_CYCLES, READ_WAIT));
  localparam int PH_W   = $clog2(PH_MAX) + 1;

  localparam logic [PH_W-1:0] CLR_LOAD    = PH_W'(CLR_CYCLES - 1);
  localparam logic [PH_W-1:0] SETTLE_LOAD = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0] READ_LOAD   = PH_W'(READ_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_READ,
    S_DONE
  } state_t;

  state_t           state, state_d;
  logic [PH_W-1:0]  ph_cnt, ph_cnt_d;
  logic [WIN_W-1:0] win_cnt, win_cnt_d;
  logic [2:0]       byte_idx, byte_idx_d;
  logic             osc_stop_d, osc_clear_d, busy_d, res_valid_d;
  logic [5:0]       osc_shift_d;
  logic [63:0]      res_count_d;
  logic             capture;
  logic             accept;
  logic             restart_req;
  logic [2:0]       byte_idx_inc;
  logic [WIN_W-1:0] win_load;

  // Bytes 0..6 are parked here; byte 7 goes straight into res_count on the
  // final read, so the top byte never needs a shadow slot.
  logic [55:0]      shadow;

`ifdef RINGOSC_SEQ_CONT_EN
  assign restart_req = start | cont;
`else
  logic cont_unused;
  assign cont_unused = cont;
  assign restart_req = start;
`endif

  // The window down-counter stops at zero, so a zero request is folded
  // into a one-cycle window instead of wrapping to 2**WIN_W.
  assign win_load     = (win_cycles == '0) ? '0 : win_cycles - WIN_W'(1);
  assign byte_idx_inc = byte_idx + 3'd1;

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d     = state;
    ph_cnt_d    = ph_cnt;
    win_cnt_d   = win_cnt;
    byte_idx_d  = byte_idx;
    osc_stop_d  = osc_stop;
    osc_clear_d = osc_clear;
    osc_shift_d = osc_shift;
    busy_d      = busy;
    res_valid_d = res_valid;
    res_count_d = res_count;
    capture     = 1'b0;
    accept      = 1'b0;

    case (state)
      S_IDLE: begin
        osc_stop_d  = 1'b1;
        osc_clear_d = 1'b0;
        osc_shift_d = 6'd0;
        if (start) begin
          accept = 1'b1;
        end
      end

      S_CLEAR: begin
        if (ph_cnt == '0) begin
          state_d     = S_RUN;
          osc_clear_d = 1'b0;
          osc_stop_d  = 1'b0;
        end else begin
          ph_cnt_d = ph_cnt - PH_W'(1);
        end
      end

      S_RUN: begin
        if (win_cnt == '0) begin
          state_d    = S_SETTLE;
          osc_stop_d = 1'b1;
          ph_cnt_d   = SETTLE_LOAD;
        end else begin
          win_cnt_d = win_cnt - WIN_W'(1);
        end
      end

      S_SETTLE: begin
        if (ph_cnt == '0) begin
          state_d     = S_READ;
          byte_idx_d  = 3'd0;
          osc_shift_d = 6'd0;
          ph_cnt_d    = READ_LOAD;
        end else begin
          ph_cnt_d = ph_cnt - PH_W'(1);
        end
      end

      S_READ: begin
        if (ph_cnt == '0) begin
          // Last cycle of this shift setting: the byte has had READ_WAIT
          // cycles to propagate through the macro's output mux.
          capture = 1'b1;
          if (byte_idx == 3'd7) begin
            state_d     = S_DONE;
            res_count_d = {osc_byte, shadow};
            res_valid_d = 1'b1;
            busy_d      = 1'b0;
            osc_shift_d = 6'd0;
          end else begin
            byte_idx_d  = byte_idx_inc;
            osc_shift_d = {byte_idx_inc, 3'b000};
            ph_cnt_d    = READ_LOAD;
          end
        end else begin
          ph_cnt_d = ph_cnt - PH_W'(1);
        end
      end

      S_DONE: begin
        // Result is held until the host takes it; start alone cannot
        // overwrite an unaccepted count.
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (restart_req) begin
            accept = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      state_d     = S_CLEAR;
      ph_cnt_d    = CLR_LOAD;
      win_cnt_d   = win_load;
      busy_d      = 1'b1;
      osc_clear_d = 1'b1;
      osc_stop_d  = 1'b1;
      osc_shift_d = 6'd0;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ph_cnt    <= '0;
      win_cnt   <= '0;
      byte_idx  <= 3'd0;
      osc_stop  <= 1'b1;
      osc_clear <= 1'b1;
      osc_shift <= 6'd0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_count <= 64'd0;
    end else begin
      state     <= state_d;
      ph_cnt    <= ph_cnt_d;
      win_cnt   <= win_cnt_d;
      byte_idx  <= byte_idx_d;
      osc_stop  <= osc_stop_d;
      osc_clear <= osc_clear_d;
      osc_shift <= osc_shift_d;
      busy      <= busy_d;
      res_valid <= res_valid_d;
      res_count <= res_count_d;
    end
  end

  // NOTE: the shadow is pure datapath with no reset; every slot is rewritten
  // before it is read, so stale data after a reset can never reach res_count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 7; i++) begin
      if (capture && (byte_idx == 3'(i))) begin
        shadow[i*8 +: 8] <= osc_byte;
      end
    end
  end

endmodule

// File: tb/tb_ringosc_meas_seq.sv
// -----------------------------------------------------------------------------
// tb_ringosc_meas_seq
//
// Self-checking bench for ringosc_meas_seq. A behavioural counter macro adds
// INC per clk while osc_stop is low and loads clr_val while osc_clear is
// high. A transaction-level model (idle / busy / done with a latency
// count-down) predicts busy and res_valid every cycle and pushes the
// expected count into a scoreboard queue when a start is accepted; an
// independent monitor pops and compares on every rising res_valid.
// -----------------------------------------------------------------------------
module tb_ringosc_meas_seq;

  localparam int WIN_W    = 16;
  localparam int CLR      = 4;
  localparam int SETTLE   = 8;
  localparam int RW       = 2;
  localparam int INC      = 3;
  localparam int LAT_BASE = CLR + SETTLE + 8 * RW;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             cont = 1'b0;
  logic [WIN_W-1:0] win_cycles = '0;
  logic             busy;
  logic             osc_stop;
  logic             osc_clear;
  logic [5:0]       osc_shift;
  logic [7:0]       osc_byte;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [63:0]      res_count;

  always #5 clk = ~clk;

  ringosc_meas_seq #(
    .WIN_W        (WIN_W),
    .CLR_CYCLES   (CLR),
    .SETTLE_CYCLES(SETTLE),
    .READ_WAIT    (RW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cont      (cont),
    .win_cycles(win_cycles),
    .busy      (busy),
    .osc_stop  (osc_stop),
    .osc_clear (osc_clear),
    .osc_shift (osc_shift),
    .osc_byte  (osc_byte),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_count (res_count)
  );

  // ---------------- counter macro model ----------------
  logic [63:0] macro_cnt = 64'd0;
  logic [63:0] clr_val   = 64'd0;

  always @(negedge clk) begin
    if (osc_clear) macro_cnt <= clr_val;
    else if (!osc_stop) macro_cnt <= macro_cnt + 64'(INC);
  end

  assign osc_byte = 8'(macro_cnt >> osc_shift);

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_results = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef enum {M_IDLE, M_BUSY, M_DONE} mphase_t;
  typedef struct {
    logic [63:0] count;
    int          n;
    int          acc_cyc;
  } exp_t;

  mphase_t m_phase = M_IDLE;
  int      m_left  = 0;
  exp_t    exp_q[$];

  function automatic int eff_win(input logic [WIN_W-1:0] w);
    return (w == '0) ? 1 : int'(w);
  endfunction

  task automatic model_accept();
    exp_t e;
    e.n       = eff_win(win_cycles);
    e.count   = clr_val + 64'(INC) * 64'(e.n);
    e.acc_cyc = cyc + 1;
    exp_q.push_back(e);
    m_phase = M_BUSY;
    m_left  = LAT_BASE + e.n;
  endtask

  logic cont_active;
`ifdef RINGOSC_SEQ_CONT_EN
  assign cont_active = cont;
`else
  assign cont_active = 1'b0;
`endif

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_phase = M_IDLE;
        exp_q.delete();
      end else begin
        check("busy", busy, m_phase == M_BUSY);
        check("res_valid", res_valid, m_phase == M_DONE);
        case (m_phase)
          M_IDLE: if (start) model_accept();
          M_BUSY: begin
            if (m_left == 1) m_phase = M_DONE;
            else m_left--;
          end
          M_DONE: begin
            if (res_ready) begin
              if (start || cont_active) model_accept();
              else m_phase = M_IDLE;
            end
          end
          default: m_phase = M_IDLE;
        endcase
      end
    end
  end

  // ---------------- result monitor ----------------
  logic        prev_valid = 1'b0;
  int          stop_low   = 0;
  logic [5:0]  trace[$];
  logic [63:0] last_count = 64'd0;

  initial begin
    exp_t e;
    int   bad;
    int   exp_s;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        stop_low   = 0;
        trace.delete();
      end else begin
        if (!osc_stop) stop_low++;
        if (busy && osc_stop && !osc_clear && stop_low > 0) trace.push_back(osc_shift);
        if (!busy) check("shift_zero_outside_read", osc_shift, 6'd0);
        if (res_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got count %0h, expected no result", res_count);
          end else begin
            e = exp_q.pop_front();
            check("res_count", res_count, e.count);
            check("latency", cyc - e.acc_cyc, LAT_BASE + e.n);
            check("stop_low_cycles", stop_low, e.n);
            check("shift_trace_len", trace.size(), SETTLE + 8 * RW);
            bad = 0;
            foreach (trace[i]) begin
              exp_s = (i < SETTLE) ? 0 : ((i - SETTLE) / RW) * 8;
              if (int'(trace[i]) != exp_s) bad++;
            end
            check("shift_trace_bad_entries", bad, 0);
            last_count = e.count;
            n_results++;
          end
          stop_low = 0;
          trace.delete();
        end else if (res_valid) begin
          check("res_count_hold", res_count, last_count);
        end
        prev_valid = res_valid;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (!(m_phase == M_IDLE && exp_q.size() == 0) && i < budget) begin
      tick();
      i++;
    end
    checks++;
    if (i >= budget) begin
      errors++;
      $display("FAIL idle_timeout: waited %0d cycles, limit %0d", i, budget);
    end
  endtask

  task automatic wait_valid(input int budget);
    int i = 0;
    while (!res_valid && i < budget) begin
      tick();
      i++;
    end
    checks++;
    if (i >= budget) begin
      errors++;
      $display("FAIL valid_timeout: waited %0d cycles, limit %0d", i, budget);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_osc_stop", osc_stop, 1'b1);
    check("rst_osc_clear", osc_clear, 1'b1);
    check("rst_osc_shift", osc_shift, 6'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_count", res_count, 64'd0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n0;
    int n;
    #1;
    do_reset();
    tick();

    // Basic window of 100 cycles from a cleared counter.
    clr_val    = 64'd0;
    win_cycles = WIN_W'(100);
    res_ready  = 1'b1;
    pulse_start();
    wait_valid(400);
    check("basic_count_300", res_count, 64'd300);
    wait_idle(50);

    // Preloaded counter reaching a known byte pattern.
    n          = $urandom_range(1, 300);
    clr_val    = 64'h0123_4567_89AB_CDEF - 64'(INC * n);
    win_cycles = WIN_W'(n);
    res_ready  = 1'b0;
    pulse_start();
    wait_valid(600);
    check("pattern_count", res_count, 64'h0123_4567_89AB_CDEF);
    res_ready = 1'b1;
    wait_idle(50);

    // Zero window plus start and window changes while busy.
    clr_val    = 64'd77;
    win_cycles = '0;
    n0         = n_results;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      start      = (i == 3);
      win_cycles = WIN_W'($urandom);
      tick();
    end
    start = 1'b0;
    wait_idle(100);
    check("single_result_zero_win", n_results - n0, 1);

    // Result held with res_ready low while start pulses, then combined
    // handshake + start.
    clr_val    = 64'd5;
    win_cycles = WIN_W'(20);
    res_ready  = 1'b0;
    pulse_start();
    wait_valid(200);
    for (int i = 0; i < 50; i++) begin
      start = 1'($urandom);
      tick();
      check("no_clear_while_held", osc_clear, 1'b0);
    end
    start     = 1'b1;
    res_ready = 1'b1;
    tick();
    start = 1'b0;
    check("clear_after_handshake", osc_clear, 1'b1);
    check("valid_drop_after_handshake", res_valid, 1'b0);
    wait_idle(200);

    // Reset during RUN, then a clean measurement.
    clr_val    = 64'd1000;
    win_cycles = WIN_W'(200);
    pulse_start();
    begin
      int i = 0;
      while (osc_stop && i < 20) begin
        tick();
        i++;
      end
      check("reached_run", osc_stop, 1'b0);
    end
    repeat (5) tick();
    do_reset();
    tick();
    clr_val    = 64'd9;
    win_cycles = WIN_W'(40);
    pulse_start();
    wait_idle(200);

    // Continuous mode request.
    clr_val    = 64'd0;
    win_cycles = WIN_W'(100);
    cont       = 1'b1;
    res_ready  = 1'b1;
    n0         = n_results;
    pulse_start();
`ifdef RINGOSC_SEQ_CONT_EN
    begin
      int i = 0;
      while (n_results - n0 < 3 && i < 1000) begin
        tick();
        i++;
      end
      check("cont_three_results", n_results - n0 >= 3, 1'b1);
    end
    cont = 1'b0;
    wait_idle(300);
`else
    wait_idle(300);
    repeat (20) tick();
    check("cont_ignored_single", n_results - n0, 1);
`endif
    cont = 1'b0;

    // Randomized measurements with noise on start/win while busy.
    for (int t = 0; t < 8; t++) begin
      clr_val    = {$urandom, $urandom};
      win_cycles = (t == 2) ? '0 : WIN_W'($urandom_range(1, 150));
      res_ready  = 1'b0;
`ifndef RINGOSC_SEQ_CONT_EN
      cont = 1'($urandom);
`endif
      pulse_start();
      for (int i = 0; i < 30; i++) begin
        start      = 1'($urandom);
        win_cycles = WIN_W'($urandom);
        tick();
      end
      start = 1'b0;
      wait_valid(400);
      repeat ($urandom_range(0, 5)) tick();
      res_ready = 1'b1;
      wait_idle(50);
    end
    cont      = 1'b0;
    res_ready = 1'b0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ringosc_meas_seq.md
Name: ringosc_meas_seq

Overview:
- Measurement sequencer for the ring-oscillator ripple-counter macro.
- Per measurement it clears the counter, ungates the oscillator for a programmed number of clk cycles, and re-gates it.
- Waits for the ripple chain to settle, then steps the counter's 6-bit shift select through 0, 8, …, 56 and assembles the 64-bit count byte by byte.
- Returns the count to the host over a valid/ready result port; it sits between the host control logic and the counter macro's stop/reset/shift/byte pins.

Parameters:
- WIN_W, 16: width of the window-length input.
- CLR_CYCLES, 4: clk cycles the counter clear is held (min 1).
- SETTLE_CYCLES, 8: clk cycles from oscillator stop to first byte read (min 1).
- READ_WAIT, 2: clk cycles between a shift change and the byte sample (min 1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  request one measurement (level-sampled)
- cont  in  1  continuous-mode request (see Optional Feature)
- win_cycles  in  WIN_W  oscillator-enabled window in clk cycles
- busy  out  1  high from start acceptance until res_valid rises
- osc_stop  out  1  to counter macro stop pin; 1 = oscillator halted
- osc_clear  out  1  to counter macro reset pin; 1 = counter cleared
- osc_shift  out  6  to counter macro shift select
- osc_byte  in  8  counter macro output byte (count >> osc_shift)[7:0]
- res_valid  out  1  result available
- res_ready  in  1  host accepts result
- res_count  out  64  captured count

Behaviour:
- Reset values (asynchronous): state IDLE, osc_stop=1, osc_clear=1, osc_shift=0, busy=0, res_valid=0, res_count=0.
- Reset mid-measurement aborts immediately and discards partial data.
- IDLE:
  - osc_stop=1, osc_clear=0.
  - start=1 with res_valid=0 → latch win_cycles (value 0 treated as 1), busy=1, go to CLEAR.
- CLEAR:
  - osc_clear=1, osc_stop=1 for exactly CLR_CYCLES cycles, then RUN.
- RUN:
  - osc_clear=0, osc_stop=0 for exactly N cycles (N = latched window), then SETTLE.
  - The window is timed with a WIN_W-bit down-counter; no wrap is possible.
- SETTLE:
  - osc_stop=1, osc_shift=0 for SETTLE_CYCLES cycles, then READ with byte index k=0.
- READ:
  - For k=0..7: osc_shift=8k is held READ_WAIT cycles; on the last cycle, osc_byte is captured into the byte-k slot of an internal 64-bit shadow register (bits 8k+7:8k).
  - After k=7 completes: copy the shadow to res_count, set res_valid=1, busy=0, go to DONE.
  - osc_byte is only sampled while osc_stop=1 and after settling, so no synchronizer is used.
- DONE:
  - res_valid=1 and res_count stay stable until res_valid & res_ready; then res_valid=0 and the block returns to IDLE.
  - start in DONE without res_ready is ignored; no overwrite of an unaccepted result.
  - res_ready & start in the same cycle: result accepted and a new measurement starts, going directly to CLEAR.
- start while busy is ignored; win_cycles changes during busy have no effect.
- Latency: res_valid rises exactly CLR_CYCLES+N+SETTLE_CYCLES+8*READ_WAIT clk edges after the edge that accepted start.
- osc_shift only takes values 0, 8, 16, …, 56, and is 0 outside READ.

Optional Feature:
- Macro: RINGOSC_SEQ_CONT_EN.
- Defined:
  - In DONE, when res_valid & res_ready and cont=1, a new measurement starts without start, using the current win_cycles.
  - busy re-asserts the cycle after the handshake.
- Undefined:
  - The cont input is ignored (no internal loads); each measurement needs start.

Test Plan:
- Bench counter model adds 3 per clk while osc_stop=0 and clears on osc_clear; win_cycles=100, start pulse → res_count=300; res_valid rises at edge 4+100+8+16=128 after acceptance; osc_stop was low for exactly 100 cycles.
- Model preloaded so the count reaches 0x0123_4567_89AB_CDEF → res_count=64'h0123456789ABCDEF; osc_shift sequence observed as 0, 8, …, 56, each held 2 cycles.
- win_cycles=0 → osc_stop low for exactly 1 cycle; start asserted again during busy → ignored, single result.
- res_ready held low 50 cycles after res_valid with start pulsed → res_count unchanged, no new CLEAR; then res_ready & start together → handshake and CLEAR begin in the same cycle.
- rst asserted during RUN → osc_stop=1, osc_clear=1, busy=0 immediately; after release and a new start, a clean result is produced.
- With RINGOSC_SEQ_CONT_EN, cont=1, res_ready=1 → back-to-back results every 129 cycles; with cont=0, stops after one result.
